// File: rtl/psram_pkg.sv
`default_nettype none
// =============================================================================
// psram_pkg: shared state encoding and PSRAM timing defaults.  Rev 1.0
// =============================================================================
package psram_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_POWERUP   = 3'd2,
    ST_CALIB     = 3'd3,
    ST_READY     = 3'd4,
    ST_FAULT     = 3'd5
  } psram_state_e;

  // 150 us at 162 MHz, and the controller's calibration budget.
  localparam int PSRAM_POWERUP_CYCLES = 24300;
  localparam int PSRAM_CALIB_TIMEOUT  = 65535;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psram_reset_sequencer_if.sv
`default_nettype none
// =============================================================================
// psram_reset_sequencer_if: PLL/controller-facing signals of the sequencer.  Rev 1.0
// =============================================================================
interface psram_reset_sequencer_if #(
  parameter int RETRY_W = 2
);
  logic               pll_lock;
  logic               calib_done;
  logic               ram_rst;
  logic               calib_start;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state_dbg;

  modport master (
    input  pll_lock, calib_done,
    output ram_rst, calib_start, ready, fault, retry_cnt, state_dbg
  );

  modport slave (
    output pll_lock, calib_done,
    input  ram_rst, calib_start, ready, fault, retry_cnt, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/psram_lock_sync.sv
`default_nettype none
// =============================================================================
// psram_lock_sync: SYNC_STAGES-deep flop chain for the asynchronous PLL lock.  Rev 1.0
// =============================================================================
module psram_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_lock,
  output logic o_lock_s
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_lock};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_lock_s = sync_q[SYNC_STAGES-1];
endmodule
`default_nettype wire

// File: rtl/psram_reset_sequencer.sv
`default_nettype none
// =============================================================================
// psram_reset_sequencer: lock qualify, power-up hold and calibration with retry.  Rev 1.0
// =============================================================================
module psram_reset_sequencer
  import psram_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int POWERUP_CYCLES     = PSRAM_POWERUP_CYCLES,
  parameter int CALIB_TIMEOUT      = PSRAM_CALIB_TIMEOUT,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  psram_reset_sequencer_if.master bus
);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
  // One spare code so the timeout value itself is representable.
  localparam int CNT_W   = $clog2(max3(LOCK_STABLE_CYCLES, POWERUP_CYCLES, CALIB_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   POWERUP_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(CALIB_TIMEOUT);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  psram_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               ram_rst_q, ram_rst_d;
  logic               calib_start_q, calib_start_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  psram_lock_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .i_lock   (bus.pll_lock),
    .o_lock_s (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) state_d = ST_STABLE;
      end
      ST_STABLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s)                    state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = ST_POWERUP;
      end
      ST_POWERUP: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s)                    state_d = ST_WAIT_LOCK;
        else if (cnt_q == POWERUP_LAST) state_d = ST_CALIB;
      end
      ST_CALIB: begin
        cnt_d = cnt_q + 1'b1;
        // cnt_q == 0 is the start cycle: a done level left over from before is not trusted.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if ((cnt_q != '0) && bus.calib_done) begin
          state_d = ST_READY;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_POWERUP;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_READY: begin
        if (!lock_s) state_d = ST_WAIT_LOCK;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    if (state_d == ST_WAIT_LOCK) retry_d = '0;

    // Outputs are decoded from the next state so they register alongside it.
    ram_rst_d     = !((state_d == ST_CALIB) || (state_d == ST_READY));
    calib_start_d = (state_d == ST_CALIB) && (state_q != ST_CALIB);
    ready_d       = (state_d == ST_READY);
    fault_d       = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT_LOCK;
      cnt_q         <= '0;
      retry_q       <= '0;
      ram_rst_q     <= 1'b1;
      calib_start_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      ram_rst_q     <= ram_rst_d;
      calib_start_q <= calib_start_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.ram_rst     = ram_rst_q;
  assign bus.calib_start = calib_start_q;
  assign bus.ready       = ready_q;
  assign bus.fault       = fault_q;
  assign bus.retry_cnt   = retry_q;
  assign bus.state_dbg   = state_q;
endmodule
`default_nettype wire

// File: tb/tb_psram_reset_sequencer.sv
`default_nettype none
// =============================================================================
// tb_psram_reset_sequencer: cycle-stamped scoreboard bench for the sequencer.  Rev 1.0
// =============================================================================
module tb_psram_reset_sequencer;
  import psram_pkg::*;

  localparam int SYNC_STAGES        = 2;
  localparam int LOCK_STABLE_CYCLES = 8;
  localparam int POWERUP_CYCLES     = 20;
  localparam int CALIB_TIMEOUT      = 10;
  localparam int MAX_RETRIES        = 2;
  localparam int RW                 = $clog2(MAX_RETRIES + 1);

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   starts = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  psram_reset_sequencer_if #(.RETRY_W(RW)) bus ();

  psram_reset_sequencer #(
    .SYNC_STAGES        (SYNC_STAGES),
    .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
    .POWERUP_CYCLES     (POWERUP_CYCLES),
    .CALIB_TIMEOUT      (CALIB_TIMEOUT),
    .MAX_RETRIES        (MAX_RETRIES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    int         cyc;
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  // {state, ram_rst, calib_start, ready, fault, retry_cnt}
  function automatic logic [8:0] ov(input psram_state_e st, input logic rr, input logic cs,
                                    input logic rdy, input logic flt, input logic [RW-1:0] rc);
    return {st, rr, cs, rdy, flt, rc};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input string t, input logic [8:0] v);
    sb.push_back('{c, t, v});
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (bus.calib_start === 1'b1) starts <= starts + 1;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      cur = sb.pop_front();
      check_val(cur.tag, 32'({bus.state_dbg, bus.ram_rst, bus.calib_start,
                              bus.ready, bus.fault, bus.retry_cnt}), 32'(cur.v));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d required<=%0d", cyc, 5000);
    $fatal(1);
  end

  initial begin
    int t0, d, g, c, c2, l, r, e, l2, r2, s0, f, r3;
    rst = 1'b1;
    bus.pll_lock = 1'b0;
    bus.calib_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push(cyc, "reset_state", ov(ST_WAIT_LOCK, 1, 0, 0, 0, 0));
    goto(cyc + 1);
    rst = 1'b0;

    // Nominal bring-up
    t0 = cyc;
    bus.pll_lock = 1'b1;
    push(t0 + 2,  "nom_wait",      ov(ST_WAIT_LOCK, 1, 0, 0, 0, 0));
    push(t0 + 3,  "nom_stable",    ov(ST_STABLE,    1, 0, 0, 0, 0));
    push(t0 + 10, "nom_stable_end", ov(ST_STABLE,   1, 0, 0, 0, 0));
    push(t0 + 11, "nom_powerup",   ov(ST_POWERUP,   1, 0, 0, 0, 0));
    push(t0 + 30, "nom_pu_end",    ov(ST_POWERUP,   1, 0, 0, 0, 0));
    push(t0 + 31, "nom_calib",     ov(ST_CALIB,     0, 1, 0, 0, 0));
    push(t0 + 32, "nom_calib_2",   ov(ST_CALIB,     0, 0, 0, 0, 0));
    push(t0 + 35, "nom_done_cyc",  ov(ST_CALIB,     0, 0, 0, 0, 0));
    push(t0 + 36, "nom_ready",     ov(ST_READY,     0, 0, 1, 0, 0));
    push(t0 + 40, "nom_ready_hold", ov(ST_READY,    0, 0, 1, 0, 0));
    goto(t0 + 35);
    bus.calib_done = 1'b1;
    goto(t0 + 38);
    bus.calib_done = 1'b0;

    // Lock loss in READY
    goto(t0 + 40);
    d = cyc;
    bus.pll_lock = 1'b0;
    push(d + 2, "drop_still_ready", ov(ST_READY,     0, 0, 1, 0, 0));
    push(d + 3, "drop_wait",        ov(ST_WAIT_LOCK, 1, 0, 0, 0, 0));

    // Lock glitch, then retry followed by success on the timeout cycle
    goto(d + 6);
    g = cyc;
    c = g + 37;
    c2 = c + 31;
    bus.pll_lock = 1'b1;
    push(g + 7,   "glitch_stable",  ov(ST_STABLE,    1, 0, 0, 0, 0));
    push(g + 8,   "glitch_wait",    ov(ST_WAIT_LOCK, 1, 0, 0, 0, 0));
    push(g + 9,   "glitch_restart", ov(ST_STABLE,    1, 0, 0, 0, 0));
    push(g + 36,  "glitch_pu_end",  ov(ST_POWERUP,   1, 0, 0, 0, 0));
    push(c,       "glitch_calib",   ov(ST_CALIB,     0, 1, 0, 0, 0));
    push(c + 10,  "retry_last",     ov(ST_CALIB,     0, 0, 0, 0, 0));
    push(c + 11,  "retry_powerup",  ov(ST_POWERUP,   1, 0, 0, 0, 1));
    push(c + 30,  "retry_pu_end",   ov(ST_POWERUP,   1, 0, 0, 0, 1));
    push(c2,      "retry_calib",    ov(ST_CALIB,     0, 1, 0, 0, 1));
    push(c2 + 10, "done_on_timeout", ov(ST_CALIB,    0, 0, 0, 0, 1));
    push(c2 + 11, "retry_ready",    ov(ST_READY,     0, 0, 1, 0, 1));
    goto(g + 5);
    bus.pll_lock = 1'b0;
    goto(g + 6);
    bus.pll_lock = 1'b1;
    goto(c2 + 10);
    bus.calib_done = 1'b1;

    // Stale calib_done held across re-lock
    goto(c2 + 12);
    l = cyc;
    bus.pll_lock = 1'b0;
    push(l + 3, "stale_wait", ov(ST_WAIT_LOCK, 1, 0, 0, 0, 0));
    goto(l + 5);
    r = cyc;
    e = r + 31;
    bus.pll_lock = 1'b1;
    push(e,     "stale_calib",   ov(ST_CALIB, 0, 1, 0, 0, 0));
    push(e + 1, "stale_ignored", ov(ST_CALIB, 0, 0, 0, 0, 0));
    push(e + 2, "stale_ready",   ov(ST_READY, 0, 0, 1, 0, 0));

    // Exhausted retries
    goto(e + 4);
    l2 = cyc;
    bus.pll_lock = 1'b0;
    bus.calib_done = 1'b0;
    push(l2 + 3, "exh_wait", ov(ST_WAIT_LOCK, 1, 0, 0, 0, 0));
    goto(l2 + 5);
    r2 = cyc;
    s0 = starts;
    bus.pll_lock = 1'b1;
    push(r2 + 31,  "exh_calib1", ov(ST_CALIB,   0, 1, 0, 0, 0));
    push(r2 + 42,  "exh_pu1",    ov(ST_POWERUP, 1, 0, 0, 0, 1));
    push(r2 + 62,  "exh_calib2", ov(ST_CALIB,   0, 1, 0, 0, 1));
    push(r2 + 73,  "exh_pu2",    ov(ST_POWERUP, 1, 0, 0, 0, 2));
    push(r2 + 93,  "exh_calib3", ov(ST_CALIB,   0, 1, 0, 0, 2));
    push(r2 + 103, "exh_last",   ov(ST_CALIB,   0, 0, 0, 0, 2));
    push(r2 + 104, "exh_fault",  ov(ST_FAULT,   1, 0, 0, 1, 2));
    goto(r2 + 106);
    check_val("start_pulses", 32'(starts - s0), 32'd3);
    for (int i = 0; i < 8; i++) begin
      goto(cyc + 1 + i);
      bus.pll_lock = ~bus.pll_lock;
    end
    push(cyc + 4, "fault_sticky", ov(ST_FAULT, 1, 0, 0, 1, 2));
    goto(cyc + 5);
    f = cyc;
    rst = 1'b1;
    bus.pll_lock = 1'b0;
    push(f + 1, "fault_rst", ov(ST_WAIT_LOCK, 1, 0, 0, 0, 0));
    goto(f + 1);
    rst = 1'b0;

    // Reset during POWERUP, then a clean bring-up
    goto(cyc + 3);
    r3 = cyc;
    bus.pll_lock = 1'b1;
    push(r3 + 15, "pu_before_rst", ov(ST_POWERUP,   1, 0, 0, 0, 0));
    push(r3 + 16, "pu_rst",        ov(ST_WAIT_LOCK, 1, 0, 0, 0, 0));
    goto(r3 + 15);
    rst = 1'b1;
    goto(r3 + 16);
    rst = 1'b0;
    push(r3 + 19, "post_rst_stable", ov(ST_STABLE, 1, 0, 0, 0, 0));
    push(r3 + 47, "post_rst_calib",  ov(ST_CALIB,  0, 1, 0, 0, 0));
    goto(r3 + 50);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
